// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode constants and immediate-format codes for the immediate generator stage.
package imm_gen_stage_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6,
        IMM_SH   = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: instruction word -> extended immediate, format and legality.
module imm_extract
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    localparam bit IS64 = (XLEN == 64);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_z;
    logic [XLEN-1:0] shamt_w;
    logic [XLEN-1:0] shamt_x;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_z = XLEN'(instr[19:15]);

    // Word shifts only ever take 5 bits; full-width shifts take bit 25 too on RV64.
    assign shamt_w = XLEN'(instr[24:20]);
    assign shamt_x = XLEN'({IS64 & instr[25], instr[24:20]});

    always_comb begin
        imm      = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        unique case (opcode)
            OPC_LOAD, OPC_JALR: begin
                imm      = imm_i;
                imm_type = IMM_I;
            end
            OPC_OP_IMM: begin
                if (funct3[1:0] == 2'b01) begin
                    if (!IS64 && instr[25]) begin
                        illegal = 1'b1;
                    end else begin
                        imm      = shamt_x;
                        imm_type = IMM_SH;
                    end
                end else begin
                    imm      = imm_i;
                    imm_type = IMM_I;
                end
            end
            OPC_OP_IMM_32: begin
                if (!IS64 || (funct3[1:0] == 2'b01 && instr[25])) begin
                    illegal = 1'b1;
                end else if (funct3[1:0] == 2'b01) begin
                    imm      = shamt_w;
                    imm_type = IMM_SH;
                end else begin
                    imm      = imm_i;
                    imm_type = IMM_I;
                end
            end
            OPC_STORE: begin
                imm      = imm_s;
                imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                imm      = imm_b;
                imm_type = IMM_B;
            end
            OPC_JAL: begin
                imm      = imm_j;
                imm_type = IMM_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm      = imm_u;
                imm_type = IMM_U;
            end
            OPC_SYSTEM: begin
                if (funct3[2]) begin
                    imm      = imm_z;
                    imm_type = IMM_Z;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: valid/ready stage with an output register plus one skid entry.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_imm_type,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);

    logic [XLEN-1:0]  ext_imm;
    imm_type_e        ext_type;
    logic             ext_illegal;

    logic             out_valid_reg;
    logic [XLEN-1:0]  out_imm_reg;
    logic [2:0]       out_type_reg;
    logic             out_illegal_reg;
    logic [TAG_W-1:0] out_tag_reg;

    logic             skid_valid_reg;
    logic [XLEN-1:0]  skid_imm_reg;
    logic [2:0]       skid_type_reg;
    logic             skid_illegal_reg;
    logic [TAG_W-1:0] skid_tag_reg;

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .instr    (i_instr),
        .imm      (ext_imm),
        .imm_type (ext_type),
        .illegal  (ext_illegal)
    );

    // Ready depends only on skid state, so downstream ready never reaches upstream combinationally.
    assign o_ready    = !skid_valid_reg;
    assign o_valid    = out_valid_reg;
    assign o_imm      = out_imm_reg;
    assign o_imm_type = out_type_reg;
    assign o_illegal  = out_illegal_reg;
    assign o_tag      = out_tag_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_valid_reg    <= 1'b0;
            out_imm_reg      <= '0;
            out_type_reg     <= '0;
            out_illegal_reg  <= 1'b0;
            out_tag_reg      <= '0;
            skid_valid_reg   <= 1'b0;
            skid_imm_reg     <= '0;
            skid_type_reg    <= '0;
            skid_illegal_reg <= 1'b0;
            skid_tag_reg     <= '0;
        end else if (i_flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
            // Skid full implies output full and input blocked; drain skid on output transfer.
            if (i_ready) begin
                out_imm_reg     <= skid_imm_reg;
                out_type_reg    <= skid_type_reg;
                out_illegal_reg <= skid_illegal_reg;
                out_tag_reg     <= skid_tag_reg;
                skid_valid_reg  <= 1'b0;
            end
        end else if (!out_valid_reg || i_ready) begin
            out_valid_reg <= i_valid;
            if (i_valid) begin
                out_imm_reg     <= ext_imm;
                out_type_reg    <= ext_type;
                out_illegal_reg <= ext_illegal;
                out_tag_reg     <= i_tag;
            end
        end else if (i_valid) begin
            skid_imm_reg     <= ext_imm;
            skid_type_reg    <= ext_type;
            skid_illegal_reg <= ext_illegal;
            skid_tag_reg     <= i_tag;
            skid_valid_reg   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: decode table at XLEN=32 and 64, then handshake corner cases.
module tb_imm_gen_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] tag;
    logic        out_ready;

    logic        ready32, valid32, ill32;
    logic [31:0] imm32;
    logic [2:0]  type32;
    logic [31:0] tag32;
    logic        ready64, valid64, ill64;
    logic [63:0] imm64;
    logic [2:0]  type64;
    logic [31:0] tag64;

    int total = 0;
    int bad   = 0;

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(ready32),
        .i_instr(instr), .i_tag(tag), .o_valid(valid32), .i_ready(out_ready), .o_imm(imm32),
        .o_imm_type(type32), .o_illegal(ill32), .o_tag(tag32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(ready64),
        .i_instr(instr), .i_tag(tag), .o_valid(valid64), .i_ready(out_ready), .o_imm(imm64),
        .o_imm_type(type64), .o_illegal(ill64), .o_tag(tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  t32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  t64;
        logic        ill64;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] addi_x1(input logic [11:0] imm12);
        return {imm12, 20'h00093};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rcv_n;
        int send;
        int stall_cycles;
        int first_stall;
        int first_out;
        int last_out;
        int seen;
        logic in_fire;
        logic out_fire;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
        vecs[2]  = '{32'h008000EF, 32'h00000008, 3'd5, 1'b0, 64'h0000000000000008, 3'd5, 1'b0};
        vecs[3]  = '{32'h12345537, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
        vecs[4]  = '{32'h4030D093, 32'h00000003, 3'd7, 1'b0, 64'h0000000000000003, 3'd7, 1'b0};
        vecs[5]  = '{32'h3002D073, 32'h00000005, 3'd6, 1'b0, 64'h0000000000000005, 3'd6, 1'b0};
        vecs[6]  = '{32'h0200D093, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000020, 3'd7, 1'b0};
        vecs[7]  = '{32'h0000009B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd1, 1'b0};
        vecs[8]  = '{32'hFE20AC23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0};
        vecs[9]  = '{32'h0040A103, 32'h00000004, 3'd1, 1'b0, 64'h0000000000000004, 3'd1, 1'b0};
        vecs[10] = '{32'h800080E7, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0};
        vecs[11] = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
        vecs[12] = '{32'h00000073, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
        vecs[13] = '{32'h43F0D093, 32'h00000000, 3'd0, 1'b1, 64'h000000000000003F, 3'd7, 1'b0};
        vecs[14] = '{32'h0200109B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
        vecs[15] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};
        vecs[16] = '{32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0};
        vecs[17] = '{32'h0050D09B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000005, 3'd7, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; tag = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid32", valid32, 0);
        chk("rst_ready32", ready32, 1);
        chk("rst_imm64",   imm64, 0);
        chk("rst_type64",  type64, 0);
        chk("rst_tag64",   tag64, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Decode table, one instruction per cycle with downstream always ready.
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1; instr = vecs[i].instr; tag = 32'(i + 100);
            @(negedge clk);
            chk("vec_valid32", valid32, 1);
            chk("vec_imm32",   imm32, vecs[i].imm32);
            chk("vec_type32",  type32, vecs[i].t32);
            chk("vec_ill32",   ill32, vecs[i].ill32);
            chk("vec_tag32",   tag32, 32'(i + 100));
            chk("vec_imm64",   imm64, vecs[i].imm64);
            chk("vec_type64",  type64, vecs[i].t64);
            chk("vec_ill64",   ill64, vecs[i].ill64);
            $display("vec %0d instr=%h imm32=%h t32=%0d ill32=%0d imm64=%h t64=%0d ill64=%0d",
                     i, vecs[i].instr, imm32, type32, ill32, imm64, type64, ill64);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid32", valid32, 0);

        // Backpressure: four tags back-to-back, downstream stalled for the first three cycles.
        rcv_n = 0; send = 1; stall_cycles = 0; first_stall = -1; first_out = -1; last_out = -1;
        out_ready = 1'b0; in_valid = 1'b1; tag = 32'd1; instr = addi_x1(12'd1);
        for (int cyc = 0; cyc < 20 && rcv_n < 4; cyc++) begin
            #1;
            in_fire  = in_valid && ready32;
            out_fire = valid32 && out_ready;
            if (!ready32) begin
                stall_cycles++;
                if (first_stall < 0) first_stall = cyc;
            end
            if (out_fire) begin
                rcv_n++;
                chk("bp_tag", tag32, 32'(rcv_n));
                chk("bp_imm", imm32, 32'(rcv_n));
                $display("bp cycle %0d out tag=%0d imm=%0d", cyc, tag32, imm32);
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            if (in_fire) send++;
            @(negedge clk);
            out_ready = (cyc >= 2);
            in_valid  = (send <= 4);
            tag       = 32'(send);
            instr     = addi_x1(12'(send));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count",       rcv_n, 4);
        chk("bp_first_stall", first_stall, 2);
        chk("bp_stall_len",   stall_cycles, 2);
        chk("bp_first_out",   first_out, 3);
        chk("bp_burst",       last_out - first_out, 3);
        @(negedge clk);

        // Flush with output and skid both full while an input is offered.
        out_ready = 1'b0; in_valid = 1'b1; tag = 32'h10; instr = addi_x1(12'h10);
        @(negedge clk);
        tag = 32'h11; instr = addi_x1(12'h11);
        @(negedge clk);
        chk("fl_pre_valid", valid32, 1);
        chk("fl_pre_ready", ready32, 0);
        flush = 1'b1; tag = 32'h12; instr = addi_x1(12'h12);
        @(negedge clk);
        chk("fl_valid", valid32, 0);
        chk("fl_ready", ready32, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (valid32 || valid64) seen++;
        end
        chk("fl_ghosts", seen, 0);

        // Flush with only the output full: the input that would have skidded is dropped.
        out_ready = 1'b0; in_valid = 1'b1; tag = 32'h20; instr = addi_x1(12'h20);
        @(negedge clk);
        flush = 1'b1; tag = 32'h21; instr = addi_x1(12'h21);
        @(negedge clk);
        chk("fl2_valid", valid32, 0);
        chk("fl2_ready", ready32, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (valid32) seen++;
        end
        chk("fl2_ghosts", seen, 0);

        // Asynchronous reset in the middle of a stalled stream.
        out_ready = 1'b0; in_valid = 1'b1; tag = 32'h30; instr = addi_x1(12'h30);
        @(negedge clk);
        tag = 32'h31; instr = addi_x1(12'h31);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid32", valid32, 0);
        chk("ar_valid64", valid64, 0);
        chk("ar_imm32",   imm32, 0);
        chk("ar_tag32",   tag32, 0);
        chk("ar_type32",  type32, 0);
        chk("ar_ready32", ready32, 1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; tag = 32'h40; instr = addi_x1(12'd7);
        #1;
        chk("ar_post_pre", valid32, 0);
        @(negedge clk);
        chk("ar_post_valid", valid32, 1);
        chk("ar_post_tag",   tag32, 32'h40);
        chk("ar_post_imm",   imm64, 64'd7);
        in_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Pipelined, parametrised immediate generator that sits between fetch and decode/execute. It accepts instructions through a valid/ready handshake and extracts immediates for every RV32I/RV64I format, including shift-amount and CSR zimm forms. It produces a sign/zero-extended XLEN immediate, a format tag, an illegal flag, and a passthrough tag. A 2-entry skid buffer gives full throughput under backpressure, and flush squashes in-flight entries.

Parameters:
XLEN, 32, datapath width; 32 or 64 only
TAG_W, 32, width of opaque passthrough tag (typically PC)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  synchronous squash of all held entries
i_valid  in  1  input instruction valid
o_ready  out  1  stage can accept input
i_instr  in  32  instruction word
i_tag  in  TAG_W  passthrough tag
o_valid  out  1  output valid
i_ready  in  1  downstream accepts output
o_imm  out  XLEN  extended immediate
o_imm_type  out  3  format code (see Behaviour)
o_illegal  out  1  instruction not legal for this XLEN
o_tag  out  TAG_W  tag matching o_imm

Behaviour:
- Reset (async assert, sync release): o_valid=0, o_imm=0, o_imm_type=0, o_illegal=0, o_tag=0, skid empty, o_ready=1.
- Input transfer when i_valid&o_ready. Output transfer when o_valid&i_ready.
- Latency: 1 cycle from input transfer to o_valid when the output register is free.
- Skid buffer: output register plus one skid register. If the output is held (o_valid&!i_ready) and an input transfers, the result goes to skid.
- o_ready = !skid_valid, registered; no combinational i_ready->o_ready path.
- On output transfer with skid full, skid moves to the output the next cycle and the skid is freed.
- Simultaneous output transfer and input transfer with skid empty: the output register reloads with the new result, no bubble.
- Ordering is strictly FIFO.
- i_flush: next edge clears o_valid and skid_valid. Any input presented in the same cycle is dropped. o_ready=1 the cycle after. Data registers may hold stale values.
- Type codes: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 SH (shamt).
- Decode by opcode (instr[6:0]):
  - LOAD 0000011, JALR 1100111 -> I: sext(instr[31:20]).
  - OP-IMM 0010011: funct3 001/101 -> SH; otherwise -> I.
  - STORE 0100011 -> S: sext({instr[31:25],instr[11:7]}).
  - BRANCH 1100011 -> B: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}), 13-bit source.
  - JAL 1101111 -> J: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}), 21-bit source.
  - LUI 0110111, AUIPC 0010111 -> U: sext({instr[31:12],12'b0}) to XLEN.
  - SYSTEM 1110011: funct3[2]=1 -> Z: zext(instr[19:15]); otherwise -> NONE, imm 0, not illegal.
  - OP-IMM-32 0011011: with XLEN=64 -> I or SH (5-bit shamt); with XLEN=32 -> illegal.
  - Any other opcode -> NONE, imm 0, o_illegal=1.
- SH format:
  - imm = zext(shamt). shamt = instr[25:20] when XLEN=64 OP-IMM; instr[24:20] otherwise.
  - funct7/funct6 bits are never part of the imm.
  - Illegal when instr[25]=1 with XLEN=32 or on OP-IMM-32.
- When o_illegal=1, o_imm=0 and o_imm_type=NONE.

Decomposition:
- Shared package/header imm_pkg.vh: opcode constants (reuse existing parameters.vh names where present) and IMM_* type codes.
- Sub-module imm_extract: purely combinational, instr -> {imm, type, illegal}, parametrised by XLEN.
- imm_gen_stage instantiates imm_extract and owns the handshake, skid buffer and flush logic.

Test Plan:
1. XLEN=32, instr 0xFFF00093 (addi x1,x0,-1) with i_ready=1 -> next cycle o_imm=0xFFFFFFFF, type 1, illegal 0.
2. Format sweep:
   - 0xFE000EE3 -> 0xFFFFFFFC type 3.
   - 0x008000EF -> 0x00000008 type 5.
   - 0x12345537 -> 0x12345000 type 4.
   - 0x4030D093 -> 0x00000003 type 7.
   - 0x3002D073 -> 0x00000005 type 6.
3. XLEN=64:
   - 0x12345537 -> 0x0000000012345000.
   - 0x0200D093 (srli shamt 32) -> imm 32, legal; the same word at XLEN=32 -> illegal=1.
   - 0x0000009B -> legal at XLEN=64, illegal at XLEN=32.
4. Backpressure: stream 4 instrs back-to-back, i_ready=0 for 3 cycles.
   - o_ready drops 1 cycle after the skid fills.
   - No loss or duplication; tags emerge in order; 1/cycle throughput after i_ready=1.
5. Flush with both registers full and i_valid=1 -> o_valid=0 next cycle, o_ready=1, flushed tags never appear.
6. Assert i_rst_n low mid-stream -> o_valid and all outputs 0 immediately (asynchronously); the first post-reset input emerges 1 cycle after acceptance.
